// File: rtl/alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : alu_cmd_seq
//  Purpose  : Command sequencer in front of a registered ALU. Accepts
//             commands on a valid/ready stream, drives the ALU operand and
//             opcode inputs across the ALU's register latency (including
//             multi-cycle single-bit shift sequences), intercepts
//             divide-by-zero, and returns the captured result on a
//             valid/ready response stream.
//  Ports    :
//     CLK, RST                      clock, synchronous active-high reset
//     cmd_valid/cmd_ready           command handshake
//     cmd_fun, cmd_a, cmd_b, cmd_cnt command opcode, operands, shift count
//     ALU_A, ALU_B, ALU_FUN         drive to the ALU instance
//     ALU_OUT, *_Flag               registered ALU result and class flags
//     rsp_valid/rsp_ready           response handshake
//     rsp_data, rsp_flags, rsp_err  captured result, {A,L,C,S} flags, div0
//  Revision : 1.0  initial release
// ============================================================================
module alu_cmd_seq #(
   parameter int n  = 16,
   parameter int CW = 5
) (
   input  logic            CLK,
   input  logic            RST,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [3:0]      cmd_fun,
   input  logic [n:0]      cmd_a,
   input  logic [n:0]      cmd_b,
   input  logic [CW-1:0]   cmd_cnt,
   output logic [n:0]      ALU_A,
   output logic [n:0]      ALU_B,
   output logic [3:0]      ALU_FUN,
   input  logic [n+1:0]    ALU_OUT,
   input  logic            Arith_Flag,
   input  logic            Logic_Flag,
   input  logic            CMP_Flag,
   input  logic            Shift_Flag,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [n+1:0]    rsp_data,
   output logic [3:0]      rsp_flags,
   output logic            rsp_err
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_ISSUE = 3'd1,
      S_SHIFT = 3'd2,
      S_CAPT  = 3'd3,
      S_RESP  = 3'd4
   } state_t;

   localparam logic [3:0]    c_FUN_ADD  = 4'd0;
   localparam logic [3:0]    c_FUN_DIV  = 4'd3;
   localparam logic [3:0]    c_FUN_SHR  = 4'd13;
   localparam logic [3:0]    c_FUN_SHL  = 4'd14;
   localparam logic [3:0]    c_FUN_NOP  = 4'd15;
   localparam logic [CW-1:0] c_CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

   state_t          r_state;
   state_t          w_state_nxt;

   logic [3:0]      r_fun;
   logic [n:0]      r_a;
   logic [n:0]      r_b;
   logic [CW-1:0]   r_cnt;

   logic [n+1:0]    r_rsp_data;
   logic [3:0]      r_rsp_flags;
   logic            r_rsp_err;
   logic            r_rsp_valid;

   logic            w_accept;
   logic            w_div0;
   logic            w_is_shift;

   assign cmd_ready  = (r_state == S_IDLE) & ~RST;
   assign w_accept   = cmd_valid & cmd_ready;
   assign w_div0     = (cmd_fun == c_FUN_DIV) && (cmd_b == '0);
   assign w_is_shift = (r_fun == c_FUN_SHR) || (r_fun == c_FUN_SHL);

   assign rsp_valid  = r_rsp_valid;
   assign rsp_data   = r_rsp_data;
   assign rsp_flags  = r_rsp_flags;
   assign rsp_err    = r_rsp_err;

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // ------------------------------------------------------------------
   // Next state and ALU drive. Outside ISSUE/SHIFT/CAPT the ALU sees the
   // NOP opcode with zero operands, which parks its output at zero.
   // ------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      ALU_FUN     = c_FUN_NOP;
      ALU_A       = '0;
      ALU_B       = '0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               // Divide-by-zero never touches the ALU.
               w_state_nxt = w_div0 ? S_RESP : S_ISSUE;
            end
         end
         S_ISSUE: begin
            ALU_A = r_a;
            if (w_is_shift) begin
               // Load A into the ALU result register (A + 0) so the
               // following single-bit shift steps act on it.
               ALU_FUN     = c_FUN_ADD;
               w_state_nxt = (r_cnt != '0) ? S_SHIFT : S_CAPT;
            end else begin
               ALU_FUN     = r_fun;
               ALU_B       = r_b;
               w_state_nxt = S_CAPT;
            end
         end
         S_SHIFT: begin
            ALU_FUN = r_fun;
            ALU_A   = r_a;
            if (r_cnt == c_CNT_ONE) begin
               w_state_nxt = S_CAPT;
            end
         end
         S_CAPT: begin
            // Opcode is still driven so the class flags reflect it at the
            // capture edge; the ALU result update at that edge is dropped.
            ALU_FUN     = r_fun;
            ALU_A       = r_a;
            ALU_B       = w_is_shift ? '0 : r_b;
            w_state_nxt = S_RESP;
         end
         S_RESP: begin
            if (r_rsp_valid && rsp_ready) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Command latch, shift counter and response registers
   // ------------------------------------------------------------------
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_fun       <= '0;
         r_a         <= '0;
         r_b         <= '0;
         r_cnt       <= '0;
         r_rsp_data  <= '0;
         r_rsp_flags <= '0;
         r_rsp_err   <= 1'b0;
         r_rsp_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_fun <= cmd_fun;
            r_a   <= cmd_a;
            r_b   <= cmd_b;
            r_cnt <= cmd_cnt;
            if (w_div0) begin
               r_rsp_data  <= '1;
               r_rsp_flags <= 4'b1000;
               r_rsp_err   <= 1'b1;
            end
         end

         if (r_state == S_SHIFT) begin
            r_cnt <= r_cnt - c_CNT_ONE;
         end

         if (r_state == S_CAPT) begin
            r_rsp_data  <= ALU_OUT;
            r_rsp_flags <= {Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag};
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
         end

         if (r_state == S_RESP) begin
            // Entering RESP from the divide-by-zero path arrives with
            // valid low; raise it one edge later. Otherwise wait for the
            // consumer.
            if (!r_rsp_valid) begin
               r_rsp_valid <= 1'b1;
            end else if (rsp_ready) begin
               r_rsp_valid <= 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_cmd_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_cmd_seq
//  Purpose  : Self-checking bench for alu_cmd_seq with a behavioural model
//             of the registered ALU (accumulating single-bit shifts,
//             combinational class flags decoded from the opcode).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_cmd_seq;

   localparam int N  = 16;
   localparam int CW = 5;

   logic            CLK = 1'b0;
   logic            RST = 1'b1;
   logic            cmd_valid = 1'b0;
   logic            cmd_ready;
   logic [3:0]      cmd_fun = 4'd0;
   logic [N:0]      cmd_a = '0;
   logic [N:0]      cmd_b = '0;
   logic [CW-1:0]   cmd_cnt = '0;
   logic [N:0]      ALU_A;
   logic [N:0]      ALU_B;
   logic [3:0]      ALU_FUN;
   logic [N+1:0]    ALU_OUT;
   logic            Arith_Flag, Logic_Flag, CMP_Flag, Shift_Flag;
   logic            rsp_valid;
   logic            rsp_ready = 1'b0;
   logic [N+1:0]    rsp_data;
   logic [3:0]      rsp_flags;
   logic            rsp_err;

   int n_checks = 0;
   int n_pass   = 0;
   logic [3:0] fseq [0:63];

   always #5 CLK = ~CLK;

   alu_cmd_seq #(.n(N), .CW(CW)) dut (
      .CLK(CLK), .RST(RST),
      .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_fun(cmd_fun),
      .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_cnt(cmd_cnt),
      .ALU_A(ALU_A), .ALU_B(ALU_B), .ALU_FUN(ALU_FUN), .ALU_OUT(ALU_OUT),
      .Arith_Flag(Arith_Flag), .Logic_Flag(Logic_Flag),
      .CMP_Flag(CMP_Flag), .Shift_Flag(Shift_Flag),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
      .rsp_flags(rsp_flags), .rsp_err(rsp_err)
   );

   // ---------------- ALU model ----------------
   function automatic logic [N+1:0] alu_f(input logic [3:0] f, input logic [N:0] a,
                                          input logic [N:0] b, input logic [N+1:0] acc);
      logic [N+1:0] ea, eb;
      ea = {1'b0, a};
      eb = {1'b0, b};
      case (f)
         4'd0:  alu_f = ea + eb;
         4'd1:  alu_f = ea - eb;
         4'd2:  alu_f = ea * eb;
         4'd3:  alu_f = (eb == '0) ? '0 : ea / eb;
         4'd4:  alu_f = ea & eb;
         4'd5:  alu_f = ea | eb;
         4'd6:  alu_f = {1'b0, ~(a & b)};
         4'd7:  alu_f = {1'b0, ~(a | b)};
         4'd8:  alu_f = ea ^ eb;
         4'd9:  alu_f = {1'b0, ~(a ^ b)};
         4'd10: alu_f = (a == b) ? 18'd1 : 18'd0;
         4'd11: alu_f = (a > b)  ? 18'd2 : 18'd0;
         4'd12: alu_f = (a < b)  ? 18'd3 : 18'd0;
         4'd13: alu_f = acc >> 1;
         4'd14: alu_f = acc << 1;
         default: alu_f = '0;
      endcase
   endfunction

   always @(posedge CLK) ALU_OUT <= alu_f(ALU_FUN, ALU_A, ALU_B, ALU_OUT);

   assign Arith_Flag = (ALU_FUN <= 4'd3);
   assign Logic_Flag = (ALU_FUN >= 4'd4)  && (ALU_FUN <= 4'd9);
   assign CMP_Flag   = (ALU_FUN >= 4'd10) && (ALU_FUN <= 4'd12);
   assign Shift_Flag = (ALU_FUN == 4'd13) || (ALU_FUN == 4'd14);

   // ---------------- checking ----------------
   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
   endtask

   typedef struct {
      logic [3:0]    fun;
      logic [N:0]    a;
      logic [N:0]    b;
      logic [CW-1:0] cnt;
      logic [N+1:0]  data;
      logic [3:0]    flags;
      logic          err;
      int            lat;
   } vec_t;

   vec_t vecs [14];

   // Issue one command, measure edges from acceptance to rsp_valid, check
   // the response, optionally stall the consumer, then complete the handshake.
   task automatic run_vec(input string tag, input vec_t v, input int hold);
      int guard;
      int lat;
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_fun   = v.fun;
      cmd_a     = v.a;
      cmd_b     = v.b;
      cmd_cnt   = v.cnt;
      rsp_ready = 1'b0;
      guard = 0;
      while (!cmd_ready && guard < 50) begin
         @(negedge CLK);
         guard++;
      end
      @(posedge CLK);
      #1;
      cmd_valid = 1'b0;
      lat = 0;
      fseq[0] = ALU_FUN;
      while (!rsp_valid && lat < 200) begin
         @(posedge CLK);
         #1;
         lat++;
         if (lat < 64) fseq[lat] = ALU_FUN;
      end
      chk({tag, "_valid"}, rsp_valid, 1);
      chk({tag, "_lat"},   lat,       v.lat);
      chk({tag, "_data"},  rsp_data,  v.data);
      chk({tag, "_flags"}, rsp_flags, v.flags);
      chk({tag, "_err"},   rsp_err,   v.err);
      for (int i = 0; i < hold; i++) begin
         @(posedge CLK);
         #1;
         chk({tag, "_hold_valid"}, rsp_valid, 1);
         chk({tag, "_hold_data"},  rsp_data,  v.data);
         chk({tag, "_hold_flags"}, rsp_flags, v.flags);
         chk({tag, "_hold_cmdrdy"}, cmd_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge CLK);
      #1;
      rsp_ready = 1'b0;
      chk({tag, "_drop"},   rsp_valid, 0);
      chk({tag, "_cmdrdy"}, cmd_ready, 1);
      chk({tag, "_keep"},   rsp_data,  v.data);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [3:0] exp_seq [0:4];
      int seen;

      //          fun    a        b       cnt   data     flags    err  lat
      vecs[0]  = '{4'd0,  17'd100000, 17'd50000, 5'd0,  18'd150000, 4'b1000, 1'b0, 2};
      vecs[1]  = '{4'd1,  17'd3,      17'd5,     5'd0,  18'd262142, 4'b1000, 1'b0, 2};
      vecs[2]  = '{4'd11, 17'd9,      17'd4,     5'd0,  18'd2,      4'b0010, 1'b0, 2};
      vecs[3]  = '{4'd14, 17'd5,      17'd0,     5'd3,  18'd40,     4'b0001, 1'b0, 5};
      vecs[4]  = '{4'd13, 17'd5,      17'd0,     5'd0,  18'd5,      4'b0001, 1'b0, 2};
      vecs[5]  = '{4'd3,  17'd7,      17'd0,     5'd0,  18'h3FFFF,  4'b1000, 1'b1, 1};
      vecs[6]  = '{4'd2,  17'd300,    17'd400,   5'd0,  18'd120000, 4'b1000, 1'b0, 2};
      vecs[7]  = '{4'd3,  17'd100,    17'd7,     5'd0,  18'd14,     4'b1000, 1'b0, 2};
      vecs[8]  = '{4'd4,  17'h0F0F0,  17'h00FF0, 5'd0,  18'h000F0,  4'b0100, 1'b0, 2};
      vecs[9]  = '{4'd15, 17'd1234,   17'd99,    5'd0,  18'd0,      4'b0000, 1'b0, 2};
      vecs[10] = '{4'd13, 17'd40,     17'd0,     5'd2,  18'd10,     4'b0001, 1'b0, 4};
      vecs[11] = '{4'd14, 17'd1,      17'd0,     5'd20, 18'd0,      4'b0001, 1'b0, 22};
      vecs[12] = '{4'd10, 17'd5,      17'd5,     5'd0,  18'd1,      4'b0010, 1'b0, 2};
      vecs[13] = '{4'd1,  17'd10,     17'd3,     5'd7,  18'd7,      4'b1000, 1'b0, 2};

      // ---- reset state ----
      RST = 1'b1;
      repeat (3) @(posedge CLK);
      @(negedge CLK);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_data",  rsp_data,  0);
      chk("rst_rsp_flags", rsp_flags, 0);
      chk("rst_rsp_err",   rsp_err,   0);
      chk("rst_alu_fun",   ALU_FUN,   15);
      chk("rst_alu_a",     ALU_A,     0);
      chk("rst_alu_b",     ALU_B,     0);
      RST = 1'b0;
      #1;
      chk("idle_cmd_ready", cmd_ready, 1);

      // ---- table-driven vectors ----
      for (int i = 0; i < 14; i++) begin
         run_vec($sformatf("v%0d", i), vecs[i], 0);
      end

      // ---- shift opcode sequence on the ALU: 0,14,14,14,14 ----
      exp_seq[0] = 4'd0;
      for (int i = 1; i < 5; i++) exp_seq[i] = 4'd14;
      run_vec("shl3", vecs[3], 0);
      for (int i = 0; i < 5; i++) chk($sformatf("shl3_fun%0d", i), fseq[i], exp_seq[i]);

      // ---- divide-by-zero leaves the ALU idle ----
      run_vec("div0", vecs[5], 0);
      chk("div0_fun0", fseq[0], 15);
      chk("div0_fun1", fseq[1], 15);

      // ---- consumer stall for 10 cycles ----
      run_vec("stall", vecs[0], 10);

      // ---- reset during the 2nd SHIFT cycle ----
      @(negedge CLK);
      cmd_valid = 1'b1;
      cmd_fun   = 4'd14;
      cmd_a     = 17'd5;
      cmd_b     = 17'd0;
      cmd_cnt   = 5'd8;
      rsp_ready = 1'b1;
      @(posedge CLK); #1;          // accepted -> ISSUE
      cmd_valid = 1'b0;
      @(posedge CLK); #1;          // SHIFT, cycle 1
      @(posedge CLK); #1;          // SHIFT, cycle 2
      chk("mid_fun_shift", ALU_FUN, 14);
      RST = 1'b1;
      @(posedge CLK); #1;
      chk("mid_rsp_valid", rsp_valid, 0);
      chk("mid_alu_fun",   ALU_FUN,   15);
      chk("mid_cmd_ready", cmd_ready, 0);
      chk("mid_rsp_data",  rsp_data,  0);
      RST = 1'b0;
      #1;
      chk("mid_cmd_ready_after", cmd_ready, 1);
      seen = 0;
      for (int i = 0; i < 30; i++) begin
         @(posedge CLK); #1;
         if (rsp_valid) seen++;
      end
      chk("mid_no_response", seen, 0);
      rsp_ready = 1'b0;

      // ---- recovery after abandoned command ----
      run_vec("post", vecs[2], 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
